// File: rtl/alu_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module   : alu_seq_pkg
// Contents : Control-word bit map, opcode/state enums, opcode helpers.
// Revision : 1.0 - initial release
// ============================================================================
package alu_seq_pkg;

    localparam int ADD          = 0;
    localparam int COMP         = 1;
    localparam int SUB          = 2;
    localparam int XORR         = 3;
    localparam int ANDD         = 4;
    localparam int ORR          = 5;
    localparam int ACC_IN       = 6;
    localparam int ACC_OUT      = 7;
    localparam int REG_OUT_BASE = 8;
    localparam int REG_IN_BASE  = 16;
    localparam int IMM_OUT      = 24;
    localparam int Z_OUT        = 25;
    localparam int FLAG_OUT     = 26;

    localparam logic [3:0] SRC_IMM = 4'd8;

    typedef enum logic [2:0] {
        OP_ADD    = 3'd0,
        OP_COMP   = 3'd1,
        OP_SUB    = 3'd2,
        OP_XOR    = 3'd3,
        OP_AND    = 3'd4,
        OP_OR     = 3'd5,
        OP_STORE  = 3'd6,
        OP_RDFLAG = 3'd7
    } opcode_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_WB   = 2'd2,
        ST_ERR  = 2'd3
    } state_e;

    // Opcodes that read a source operand (and can therefore have an illegal src)
    function automatic logic uses_src(input opcode_e op);
        return (op <= OP_OR);
    endfunction

    // Opcodes that need an accumulator write-back T-state
    function automatic logic needs_wb(input opcode_e op);
        return (op <= OP_OR) && (op != OP_COMP);
    endfunction

endpackage
`default_nettype wire

// File: rtl/alu_sequencer_cs_decode.sv
`default_nettype none
// ============================================================================
// Module   : cs_decode
// Contents : Maps {next state, opcode, src, dst} to the one-hot control word.
// Revision : 1.0 - initial release
// ============================================================================
module cs_decode
    import alu_seq_pkg::*;
#(
    parameter int SZ = 28
) (
    input  state_e        i_next_state,
    input  opcode_e       i_opcode,
    input  logic [3:0]    i_src,
    input  logic [2:0]    i_dst,
    output logic [SZ-1:0] o_cs
);

    logic [7:0] w_src_oh;
    logic [7:0] w_dst_oh;
    logic [5:0] w_func_oh;

    always_comb begin
        w_src_oh  = 8'b1 << i_src[2:0];
        w_dst_oh  = 8'b1 << i_dst;
        w_func_oh = 6'b1 << i_opcode;
        o_cs      = '0;
        case (i_next_state)
            ST_EXEC: begin
                case (i_opcode)
                    OP_STORE: begin
                        o_cs[ACC_OUT]            = 1'b1;
                        o_cs[REG_IN_BASE +: 8]   = w_dst_oh;
                    end
                    OP_RDFLAG: begin
                        o_cs[FLAG_OUT] = 1'b1;
                        o_cs[ACC_IN]   = 1'b1;
                    end
                    default: begin
                        o_cs[ADD +: 6] = w_func_oh;
                        // Illegal sources never reach EXEC, so only r0-r7 / imm remain
                        if (i_src == SRC_IMM)
                            o_cs[IMM_OUT] = 1'b1;
                        else if (!i_src[3])
                            o_cs[REG_OUT_BASE +: 8] = w_src_oh;
                    end
                endcase
            end
            ST_WB: begin
                o_cs[Z_OUT]  = 1'b1;
                o_cs[ACC_IN] = 1'b1;
            end
            default: o_cs = '0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/alu_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : alu_sequencer
// Contents : T-state FSM driving the ALU datapath control word, with retire count.
// Revision : 1.0 - initial release
// ============================================================================
module alu_sequencer
    import alu_seq_pkg::*;
#(
    parameter int SZ    = 28,
    parameter int CNT_W = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             op_valid,
    output logic             op_ready,
    input  logic [2:0]       opcode,
    input  logic [3:0]       src,
    input  logic [2:0]       dst,
    output logic [SZ-1:0]    CS_bus,
    output logic             done,
    output logic             err,
    output logic [CNT_W-1:0] retired
);

    state_e           r_state;
    opcode_e          r_opcode;
    logic [3:0]       r_src;
    logic [2:0]       r_dst;
    logic [SZ-1:0]    r_cs;
    logic             r_done;
    logic             r_err;
    logic [CNT_W-1:0] r_retired;

    state_e           w_next_state;
    opcode_e          w_in_opcode;
    opcode_e          w_dec_opcode;
    logic [3:0]       w_dec_src;
    logic [2:0]       w_dec_dst;
    logic             w_xfer;
    logic             w_illegal;
    logic             w_done_next;
    logic             w_err_next;
    logic [SZ-1:0]    w_cs;

    assign op_ready = (r_state == ST_IDLE) & ~RST;
    assign CS_bus   = r_cs;
    assign done     = r_done;
    assign err      = r_err;
    assign retired  = r_retired;

    always_comb begin
        w_xfer       = op_valid & op_ready;
        w_in_opcode  = opcode_e'(opcode);
        w_illegal    = uses_src(w_in_opcode) && (src > SRC_IMM);
        w_next_state = r_state;
        w_done_next  = 1'b0;
        w_err_next   = 1'b0;
        // Decode the live inputs on the transfer edge, the captured copy afterwards
        w_dec_opcode = r_opcode;
        w_dec_src    = r_src;
        w_dec_dst    = r_dst;
        case (r_state)
            ST_IDLE: begin
                if (w_xfer) begin
                    w_dec_opcode = w_in_opcode;
                    w_dec_src    = src;
                    w_dec_dst    = dst;
                    if (w_illegal) begin
                        w_next_state = ST_ERR;
                        w_err_next   = 1'b1;
                    end else begin
                        w_next_state = ST_EXEC;
                        w_done_next  = ~needs_wb(w_in_opcode);
                    end
                end
            end
            ST_EXEC: begin
                if (needs_wb(r_opcode)) begin
                    w_next_state = ST_WB;
                    w_done_next  = 1'b1;
                end else begin
                    w_next_state = ST_IDLE;
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    cs_decode #(
        .SZ (SZ)
    ) u_cs_decode (
        .i_next_state (w_next_state),
        .i_opcode     (w_dec_opcode),
        .i_src        (w_dec_src),
        .i_dst        (w_dec_dst),
        .o_cs         (w_cs)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state   <= ST_IDLE;
            r_opcode  <= OP_ADD;
            r_src     <= 4'd0;
            r_dst     <= 3'd0;
            r_cs      <= '0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
            r_retired <= '0;
        end else begin
            r_state   <= w_next_state;
            r_cs      <= w_cs;
            r_done    <= w_done_next;
            r_err     <= w_err_next;
            r_retired <= r_retired + {{(CNT_W-1){1'b0}}, r_done};
            if (w_xfer) begin
                r_opcode <= w_in_opcode;
                r_src    <= src;
                r_dst    <= dst;
            end
        end
    end

endmodule
`default_nettype wire
